video_cmd_queue: RTL and testbench

VIDEO_CMD_QUEUE -- requirements
Module: video_cmd_queue

---
 rtl/video_cmd_queue.sv | 195 +++++++++++++++++++
 tb/tb_video_cmd_queue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_cmd_queue.sv
// Register-programmed per-channel command FIFOs feeding video function units.
// Optional idle interrupt: define VIDEO_CMD_QUEUE_IRQ_EN to enable offset 12 and irq.
module video_cmd_queue #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned NR_FUN_UNITS = 2,
  parameter int unsigned DEST_WIDTH   = 3
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                reg_en,
  input  logic                reg_we,
  input  logic [11:0]         reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic [N_CH-1:0]     cmd_valid,
  input  logic [N_CH-1:0]     cmd_ready,
  output logic [64*N_CH-1:0]  cmd_data,
  input  logic [N_CH-1:0]     cmd_done,
  output logic                irq
);

  localparam int unsigned           DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEST_WIDTH-1:0] MAX_DEST = DEST_WIDTH'(NR_FUN_UNITS);
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [3:0] offset;
  logic       wr_en;
  logic [N_CH:0][31:0] rd_chain;

  assign offset      = reg_addr[3:0];
  assign wr_en       = reg_en && reg_we;
  assign rd_chain[0] = '0;

`ifdef VIDEO_CMD_QUEUE_IRQ_EN
  logic [N_CH-1:0] irq_term;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level, level_nx;
    logic [31:0]           low_word, done_cnt, rd_local;
    logic [63:0]           push_cmd;
    logic                  sel, wr0, wr4, wr8;
    logic                  half, overflow;
    logic                  empty, full, flush, pop, push_try, push, ovf_set;

    assign sel      = reg_addr[11:4] == 8'(c);
    assign wr0      = wr_en && sel && (offset == 4'h0);
    assign wr4      = wr_en && sel && (offset == 4'h4);
    assign wr8      = wr_en && sel && (offset == 4'h8);
    assign empty    = level == '0;
    assign full     = level == FULL_LVL;
    assign flush    = wr8 && reg_wdata[0];
    assign pop      = !empty && cmd_ready[c] && !flush;
    assign push_try = wr0 && half;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push     = push_try && (!full || pop);
    assign ovf_set  = push_try && full && !pop;

    always_comb begin
      push_cmd = {reg_wdata, low_word};
      if (low_word[DEST_WIDTH-1:0] > MAX_DEST)
        push_cmd[DEST_WIDTH-1:0] = '0;
    end

    always_comb begin
      level_nx = level;
      if (flush)
        level_nx = '0;
      else if (push && !pop)
        level_nx = level + 1'b1;
      else if (pop && !push)
        level_nx = level - 1'b1;
    end

    always_ff @(posedge aclk) begin
      if (push)
        mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        low_word <= '0;
        half     <= 1'b0;
        overflow <= 1'b0;
        done_cnt <= '0;
      end else begin
        level <= level_nx;
        if (flush) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          half   <= 1'b0;
        end else begin
          if (push)
            wr_ptr <= wr_ptr + 1'b1;
          if (pop)
            rd_ptr <= rd_ptr + 1'b1;
          if (wr0) begin
            if (half) begin
              half <= 1'b0;
            end else begin
              low_word <= reg_wdata;
              half     <= 1'b1;
            end
          end
        end
        if (ovf_set)
          overflow <= 1'b1;
        else if (wr8 && reg_wdata[1])
          overflow <= 1'b0;
        if (wr4)
          done_cnt <= {31'b0, cmd_done[c]};
        else if (cmd_done[c])
          done_cnt <= done_cnt + 32'd1;
      end
    end

`ifdef VIDEO_CMD_QUEUE_IRQ_EN
    logic        wr12, mask, pending, mask_nx, pending_nx;
    logic [31:0] inflight, inflight_nx;

    assign wr12 = wr_en && sel && (offset == 4'hC);

    // irq is registered from next-state values so it rises the cycle after the event.
    always_comb begin
      inflight_nx = inflight;
      if (pop && !cmd_done[c])
        inflight_nx = inflight + 32'd1;
      else if (!pop && cmd_done[c] && inflight != '0)
        inflight_nx = inflight - 32'd1;
      mask_nx    = wr12 ? reg_wdata[0] : mask;
      pending_nx = pending;
      if (wr12 && reg_wdata[1])
        pending_nx = 1'b0;
      if (inflight == 32'd1 && inflight_nx == '0 && level_nx == '0)
        pending_nx = 1'b1;
    end

    assign irq_term[c] = mask_nx && (level_nx == '0) && (inflight_nx == '0) && pending_nx;

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        inflight <= '0;
        mask     <= 1'b0;
        pending  <= 1'b0;
      end else begin
        inflight <= inflight_nx;
        mask     <= mask_nx;
        pending  <= pending_nx;
      end
    end
`endif

    always_comb begin
      rd_local = '0;
      case (offset)
        4'h0: rd_local = 32'(level);
        4'h4: rd_local = done_cnt;
        4'h8: rd_local = {28'b0, overflow, half, full, empty};
`ifdef VIDEO_CMD_QUEUE_IRQ_EN
        4'hC: rd_local = {31'b0, mask};
`endif
        default: rd_local = '0;
      endcase
    end

    assign rd_chain[c+1]        = rd_chain[c] | (sel ? rd_local : 32'b0);
    assign cmd_valid[c]         = !empty;
    assign cmd_data[64*c +: 64] = mem[rd_ptr];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      reg_rdata <= '0;
    else if (reg_en && !reg_we)
      reg_rdata <= rd_chain[N_CH];
  end

`ifdef VIDEO_CMD_QUEUE_IRQ_EN
  always_ff @(posedge aclk) begin
    if (!aresetn)
      irq <= 1'b0;
    else
      irq <= |irq_term;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_video_cmd_queue.sv
// Self-checking bench for video_cmd_queue: directed scenarios plus randomized traffic
// against a queue-based behavioural model.
module tb_video_cmd_queue;
  localparam int N_CH         = 2;
  localparam int DEPTH_LOG2   = 3;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int NR_FUN_UNITS = 2;
  localparam int DEST_WIDTH   = 3;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic                reg_en = 1'b0, reg_we = 1'b0;
  logic [11:0]         reg_addr = '0;
  logic [31:0]         reg_wdata = '0;
  logic [31:0]         reg_rdata;
  logic [N_CH-1:0]     cmd_valid;
  logic [N_CH-1:0]     cmd_ready = '0;
  logic [64*N_CH-1:0]  cmd_data;
  logic [N_CH-1:0]     cmd_done = '0;
  logic                irq;

  int n_total = 0;
  int n_bad   = 0;

  video_cmd_queue #(
    .N_CH(N_CH), .DEPTH_LOG2(DEPTH_LOG2), .NR_FUN_UNITS(NR_FUN_UNITS), .DEST_WIDTH(DEST_WIDTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .reg_en(reg_en), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_done(cmd_done), .irq(irq)
  );

  always #5 aclk = ~aclk;

  // Behavioural model state
  logic [63:0] mq [N_CH][$];
  bit          m_half [N_CH];
  logic [31:0] m_low  [N_CH];
  bit          m_ovf  [N_CH];
  logic [31:0] m_done [N_CH];
  int unsigned m_infl [N_CH];
  bit          m_pend [N_CH];
  bit          m_mask [N_CH];
  bit          m_irq;
  logic [31:0] m_rd;

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      mq[c].delete();
      m_half[c] = 0; m_low[c] = '0; m_ovf[c] = 0; m_done[c] = '0;
      m_infl[c] = 0; m_pend[c] = 0; m_mask[c] = 0;
    end
    m_irq = 0;
    m_rd  = '0;
  endtask

  function automatic logic [31:0] m_read(logic [11:0] a);
    int ch;
    ch = int'(a[11:4]);
    if (ch >= N_CH) return '0;
    case (a[3:0])
      4'h0: return 32'(mq[ch].size());
      4'h4: return m_done[ch];
      4'h8: return {28'b0, m_ovf[ch], m_half[ch], mq[ch].size() == DEPTH, mq[ch].size() == 0};
`ifdef VIDEO_CMD_QUEUE_IRQ_EN
      4'hC: return {31'b0, m_mask[ch]};
`endif
      default: return '0;
    endcase
  endfunction

  // Apply one cycle of inputs at a negedge, advance the model, and step to the next negedge.
  task automatic cycle(bit en, bit we, logic [11:0] a, logic [31:0] wd,
                       logic [N_CH-1:0] rdy, logic [N_CH-1:0] dn);
    bit irq_any;
    reg_en = en; reg_we = we; reg_addr = a; reg_wdata = wd;
    cmd_ready = rdy; cmd_done = dn;
    if (en && !we) m_rd = m_read(a);
    irq_any = 0;
    for (int c = 0; c < N_CH; c++) begin
      bit wr, flush, pop;
      int unsigned old_infl;
      logic [63:0] cmd;
      wr    = en && we && (int'(a[11:4]) == c);
      flush = wr && a[3:0] == 4'h8 && wd[0];
      pop   = mq[c].size() != 0 && rdy[c] && !flush;
      old_infl = m_infl[c];
      if (pop) void'(mq[c].pop_front());
      if (flush) begin
        mq[c].delete();
        m_half[c] = 0;
      end
      if (wr && a[3:0] == 4'h0) begin
        if (!m_half[c]) begin
          m_low[c]  = wd;
          m_half[c] = 1;
        end else begin
          m_half[c] = 0;
          cmd = {wd, m_low[c]};
          if (int'(cmd[DEST_WIDTH-1:0]) > NR_FUN_UNITS) cmd[DEST_WIDTH-1:0] = '0;
          if (mq[c].size() < DEPTH) mq[c].push_back(cmd);
          else m_ovf[c] = 1;
        end
      end
      if (wr && a[3:0] == 4'h8 && wd[1]) m_ovf[c] = 0;
      if (wr && a[3:0] == 4'h4) m_done[c] = dn[c] ? 32'd1 : 32'd0;
      else if (dn[c]) m_done[c] = m_done[c] + 32'd1;
`ifdef VIDEO_CMD_QUEUE_IRQ_EN
      if (pop && !dn[c]) m_infl[c]++;
      else if (dn[c] && !pop && m_infl[c] > 0) m_infl[c]--;
      if (wr && a[3:0] == 4'hC) begin
        m_mask[c] = wd[0];
        if (wd[1]) m_pend[c] = 0;
      end
      if (old_infl == 1 && m_infl[c] == 0 && mq[c].size() == 0) m_pend[c] = 1;
      if (m_mask[c] && mq[c].size() == 0 && m_infl[c] == 0 && m_pend[c]) irq_any = 1;
`else
      if (old_infl != 0) irq_any = 0;
`endif
    end
    m_irq = irq_any;
    @(negedge aclk);
    reg_en = 0; reg_we = 0; cmd_ready = '0; cmd_done = '0;
  endtask

  task automatic do_reset();
    aresetn = 0; reg_en = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;
    cmd_ready = '0; cmd_done = '0;
    repeat (3) @(negedge aclk);
    m_reset();
    aresetn = 1;
  endtask

  task automatic test_reset();
    n_total++;
    if (cmd_valid !== '0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
    n_total++;
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", reg_rdata); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    cycle(1, 0, 12'h008, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL reset_status: got %h want 1", reg_rdata); end
  endtask

  task automatic test_basic_push();
    cycle(1, 1, 12'h000, 32'h1000_0002, '0, '0);
    cycle(1, 1, 12'h000, 32'h0000_0040, '0, '0);
    n_total++;
    if (cmd_valid !== 2'b01) begin n_bad++; $display("FAIL basic_valid: got %b want 01", cmd_valid); end
    n_total++;
    if (cmd_data[63:0] !== 64'h0000_0040_1000_0002)
      begin n_bad++; $display("FAIL basic_data: got %h want 0000004010000002", cmd_data[63:0]); end
    cycle(1, 0, 12'h000, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'd1) begin n_bad++; $display("FAIL basic_level: got %0d want 1", reg_rdata); end
    cycle(0, 0, '0, '0, 2'b01, '0);
    n_total++;
    if (cmd_valid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %b want 0", cmd_valid[0]); end
  endtask

  task automatic test_dest_clamp();
    logic [31:0] lows [3];
    logic [63:0] want [3];
    lows[0] = 32'hABCD_0005; want[0] = 64'h1234_5678_ABCD_0000;
    lows[1] = 32'hABCD_0003; want[1] = 64'h1234_5678_ABCD_0000;
    lows[2] = 32'hABCD_0002; want[2] = 64'h1234_5678_ABCD_0002;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 12'h000, lows[i], '0, '0);
      cycle(1, 1, 12'h000, 32'h1234_5678, '0, '0);
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (cmd_data[63:0] !== want[i])
        begin n_bad++; $display("FAIL dest_clamp[%0d]: got %h want %h", i, cmd_data[63:0], want[i]); end
      cycle(0, 0, '0, '0, 2'b01, '0);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] sent [$];
    logic [31:0] lo, hi;
    for (int i = 0; i < 9; i++) begin
      lo = ($urandom() & 32'hFFFF_FFF8) | 32'(i % 3);
      hi = $urandom();
      if (i < DEPTH) sent.push_back({hi, lo});
      cycle(1, 1, 12'h000, lo, '0, '0);
      cycle(1, 1, 12'h000, hi, '0, '0);
    end
    cycle(1, 0, 12'h000, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'd8) begin n_bad++; $display("FAIL ovf_level: got %0d want 8", reg_rdata); end
    cycle(1, 0, 12'h008, '0, '0, '0);
    n_total++;
    if (reg_rdata !== m_rd || reg_rdata !== 32'hA)
      begin n_bad++; $display("FAIL ovf_status: got %h want %h", reg_rdata, m_rd); end
    cycle(1, 0, 12'h018, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL ovf_other_ch: got %h want 1", reg_rdata); end
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (cmd_valid[0] !== 1'b1 || cmd_data[63:0] !== sent[i])
        begin n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, cmd_data[63:0], sent[i]); end
      cycle(0, 0, '0, '0, 2'b01, '0);
    end
    cycle(1, 1, 12'h008, 32'h2, '0, '0);
    cycle(1, 0, 12'h008, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL ovf_clear: got %h want 1", reg_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] sent [$];
    logic [31:0] lo, hi;
    int got_n;
    got_n = 0;
    for (int i = 0; i < 12; i++) begin
      lo = ($urandom() & 32'hFFFF_FFF8) | 32'(i % 3);
      hi = $urandom();
      sent.push_back({hi, lo});
      for (int ph = 0; ph < 2; ph++) begin
        if (cmd_valid[0]) begin
          n_total++;
          if (got_n >= sent.size() || cmd_data[63:0] !== sent[got_n])
            begin n_bad++; $display("FAIL b2b_data[%0d]: got %h", got_n, cmd_data[63:0]); end
          got_n++;
        end
        cycle(1, 1, 12'h000, (ph == 0) ? lo : hi, 2'b01, '0);
      end
    end
    if (cmd_valid[0]) begin
      n_total++;
      if (got_n >= sent.size() || cmd_data[63:0] !== sent[got_n])
        begin n_bad++; $display("FAIL b2b_data[%0d]: got %h", got_n, cmd_data[63:0]); end
      got_n++;
    end
    cycle(0, 0, '0, '0, 2'b01, '0);
    n_total++;
    if (got_n != 12) begin n_bad++; $display("FAIL b2b_count: got %0d want 12", got_n); end
    cycle(1, 0, 12'h000, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'd0) begin n_bad++; $display("FAIL b2b_level: got %0d want 0", reg_rdata); end
  endtask

  task automatic test_done_count();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, '0, '0, 2'b01);
      cycle(0, 0, '0, '0, '0, '0);
    end
    cycle(1, 0, 12'h004, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'd3) begin n_bad++; $display("FAIL done_three: got %0d want 3", reg_rdata); end
    cycle(1, 1, 12'h004, 32'h0, '0, 2'b01);
    cycle(1, 0, 12'h004, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'd1) begin n_bad++; $display("FAIL done_clear_pulse: got %0d want 1", reg_rdata); end
    cycle(1, 0, 12'h014, '0, '0, '0);
    n_total++;
    if (reg_rdata !== m_rd || reg_rdata !== 32'd0)
      begin n_bad++; $display("FAIL done_other_ch: got %0d want 0", reg_rdata); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 12'h000, 32'h100 + 32'(i), '0, '0);
      cycle(1, 1, 12'h000, 32'h200 + 32'(i), '0, '0);
    end
    cycle(1, 1, 12'h008, 32'h1, 2'b01, '0);
    n_total++;
    if (cmd_valid[0] !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", cmd_valid[0]); end
    cycle(1, 0, 12'h008, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL flush_status: got %h want 1", reg_rdata); end
    cycle(1, 1, 12'h000, 32'h11, '0, '0);
    cycle(1, 1, 12'h008, 32'h1, '0, '0);
    cycle(1, 1, 12'h000, 32'h22, '0, '0);
    cycle(1, 1, 12'h000, 32'h33, '0, '0);
    n_total++;
    if (cmd_data[63:0] !== 64'h0000_0033_0000_0022)
      begin n_bad++; $display("FAIL flush_latch: got %h want 0000003300000022", cmd_data[63:0]); end
    cycle(0, 0, '0, '0, 2'b01, '0);
  endtask

  task automatic test_irq();
    do_reset();
`ifdef VIDEO_CMD_QUEUE_IRQ_EN
    cycle(1, 1, 12'h00C, 32'h1, '0, '0);
    cycle(1, 1, 12'h000, 32'h5000_0001, '0, '0);
    cycle(1, 1, 12'h000, 32'h0000_0077, '0, '0);
    cycle(0, 0, '0, '0, 2'b01, '0);
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq); end
    cycle(0, 0, '0, '0, '0, 2'b01);
    n_total++;
    if (irq !== 1'b1 || m_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
    cycle(1, 1, 12'h00C, 32'h3, '0, '0);
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    cycle(1, 0, 12'h00C, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL irq_mask_rd: got %h want 1", reg_rdata); end
`else
    cycle(1, 1, 12'h00C, 32'h3, '0, '0);
    cycle(1, 1, 12'h000, 32'h5000_0001, '0, '0);
    cycle(1, 1, 12'h000, 32'h0000_0077, '0, '0);
    cycle(0, 0, '0, '0, 2'b01, '0);
    cycle(0, 0, '0, '0, '0, 2'b01);
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_tied: got %b want 0", irq); end
    cycle(1, 0, 12'h00C, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL irq_off12: got %h want 0", reg_rdata); end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      int r, ch;
      bit en, we;
      logic [11:0] a;
      logic [31:0] wd;
      logic [N_CH-1:0] rdy, dn;
      for (int c = 0; c < N_CH; c++) begin
        logic [63:0] got;
        got = cmd_data[64*c +: 64];
        n_total++;
        if (cmd_valid[c] !== (mq[c].size() != 0))
          begin n_bad++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %0d", c, k, cmd_valid[c], mq[c].size() != 0); end
        if (mq[c].size() != 0) begin
          n_total++;
          if (got !== mq[c][0])
            begin n_bad++; $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", c, k, got, mq[c][0]); end
        end
      end
      r  = $urandom_range(0, 99);
      ch = $urandom_range(0, N_CH);
      a  = {8'(ch), 4'h0};
      if ($urandom_range(0, 15) == 0) a[11:4] = 8'hFF;
      en = 1; we = 1; wd = $urandom();
      if (r < 45)      a[3:0] = 4'h0;
      else if (r < 50) a[3:0] = 4'h4;
      else if (r < 54) begin a[3:0] = 4'h8; wd = 32'($urandom_range(0, 3)); end
      else if (r < 58) begin a[3:0] = 4'hC; wd = 32'($urandom_range(0, 3)); end
      else if (r < 88) begin we = 0; a[3:0] = 4'($urandom_range(0, 3) * 4); end
      else en = 0;
      for (int c = 0; c < N_CH; c++) begin
        rdy[c] = (k < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        dn[c]  = ($urandom_range(0, 5) == 0);
      end
      cycle(en, we, a, wd, rdy, dn);
      if (en && !we) begin
        n_total++;
        if (reg_rdata !== m_rd)
          begin n_bad++; $display("FAIL rnd_read %h cyc %0d: got %h want %h", a, k, reg_rdata, m_rd); end
      end
      n_total++;
      if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq cyc %0d: got %b want %b", k, irq, m_irq); end
    end
  endtask

  task automatic test_reset_midway();
    cycle(1, 1, 12'h008, 32'h3, '0, '0);
    cycle(1, 1, 12'h000, 32'h0000_0AA0, '0, '0);
    cycle(1, 0, 12'h008, '0, '0, '0);
    n_total++;
    if (reg_rdata !== 32'h5) begin n_bad++; $display("FAIL mid_half: got %h want 5", reg_rdata); end
    do_reset();
    n_total++;
    if (reg_rdata !== 32'h0 || cmd_valid !== '0)
      begin n_bad++; $display("FAIL mid_reset: rdata %h valid %b want 0/0", reg_rdata, cmd_valid); end
    cycle(1, 1, 12'h000, 32'hCAFE_0001, '0, '0);
    cycle(1, 1, 12'h000, 32'hBEEF_0000, '0, '0);
    n_total++;
    if (cmd_data[63:0] !== 64'hBEEF_0000_CAFE_0001)
      begin n_bad++; $display("FAIL mid_discard: got %h want beef0000cafe0001", cmd_data[63:0]); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic_push();
    test_dest_clamp();
    test_overflow();
    test_back_to_back();
    test_done_count();
    test_flush();
    test_irq();
    test_random();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
